// File: rtl/qq_pkg.sv
// qq_pkg: shared state, entry type and sentinel helpers for QuickQ segments
`ifndef QQ_KW
`define QQ_KW 32
`endif
`ifndef QQ_VW
`define QQ_VW 16
`endif
package qq_pkg;
  localparam int QQ_KW = `QQ_KW;
  localparam int QQ_VW = `QQ_VW;
  typedef enum logic [2:0] {INIT, IDLE, ENQ, ENQ_RT, DEQ, DEQ_RT, REPL} qq_state_t;
  typedef struct packed {
    logic [QQ_KW-1:0] key;
    logic [QQ_VW-1:0] val;
  } qq_entry_t;
  localparam logic [QQ_KW-1:0] MAX_KEY = '1;
  localparam qq_entry_t SENT = '{key: MAX_KEY, val: '0};
  function automatic logic is_sentinel(input logic [QQ_KW-1:0] key);
    return &key;
  endfunction
endpackage

// File: rtl/qq_segment_mem.sv
// qq_seg_mem: segment entry storage, one write port, async reads at i, i+1 and head
module qq_seg_mem
  import qq_pkg::*;
#(
  parameter int D = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(D)-1:0] wa,
  input  qq_entry_t            wd,
  input  logic [$clog2(D)-1:0] ra,
  output qq_entry_t            rd_i,
  output qq_entry_t            rd_n,
  output qq_entry_t            rd_h
);
  localparam int IW = $clog2(D);
  qq_entry_t mem [D];
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  assign rd_i = mem[ra];
  // past the last slot the next entry reads as empty
  assign rd_n = ra == IW'(D - 1) ? SENT : mem[ra + IW'(1)];
  assign rd_h = mem[0];
endmodule

// File: rtl/qq_segment.sv
// qq_segment: one chainable sorted priority-queue segment with value payload and REPLACE
module qq_segment
  import qq_pkg::*;
#(
  parameter int KW   = QQ_KW,
  parameter int VW   = QQ_VW,
  parameter int D    = 8,
  parameter bit LAST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_i,
  input  logic          deq_i,
  input  logic [KW-1:0] key_i,
  input  logic [VW-1:0] val_i,
  output logic          rdy_o,
  output logic [KW-1:0] key_o,
  output logic [VW-1:0] val_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          ovf_o,
  output logic          rt_enq_o,
  output logic          rt_deq_o,
  output logic [KW-1:0] rt_key_o,
  output logic [VW-1:0] rt_val_o,
  input  logic [KW-1:0] rt_key_i,
  input  logic [VW-1:0] rt_val_i,
  input  logic          rt_rdy_i
);
  localparam int IW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  localparam logic [IW-1:0] TOP = IW'(D - 1);
  qq_state_t st;
  logic [IW-1:0] i, wa;
  logic [CW-1:0] cnt;
  logic empty, full, ovf, we, rt_ok, at_top, lt_cur, lt_nx, repl_push;
  qq_entry_t t, cur, nxt_m, head, rt_head, nx, wd;
  qq_seg_mem #(.D(D)) u_mem (
    .clk(clk), .we(we), .wa(wa), .wd(wd), .ra(i), .rd_i(cur), .rd_n(nxt_m), .rd_h(head)
  );
  assign rt_head   = LAST ? SENT : qq_entry_t'{key: rt_key_i, val: rt_val_i};
  assign rt_ok     = LAST || rt_rdy_i;
  assign at_top    = i == TOP;
  assign nx        = at_top ? rt_head : nxt_m;
  assign lt_cur    = t.key < cur.key;
  assign lt_nx     = t.key < nx.key;
  // a REPLACE that runs off the end hands the new entry to the right neighbour
  assign repl_push = st == REPL && at_top && rt_ok && !lt_nx;
  assign rdy_o     = st == IDLE;
  assign key_o     = st == INIT ? MAX_KEY : head.key;
  assign val_o     = head.val;
  assign empty_o   = empty;
  assign full_o    = full;
  assign ovf_o     = ovf;
  assign rt_enq_o  = !LAST && (st == ENQ_RT || repl_push);
  assign rt_deq_o  = !LAST && (repl_push || (st == DEQ_RT && rt_rdy_i && !is_sentinel(rt_key_i)));
  assign rt_key_o  = t.key;
  assign rt_val_o  = t.val;
  always_comb begin
    we = 1'b0;
    wa = i;
    wd = t;
    case (st)
      INIT:    begin we = 1'b1; wd = SENT; end
      ENQ:     we = lt_cur;
      DEQ:     begin we = 1'b1; wd = nxt_m; end
      DEQ_RT:  begin we = rt_ok; wd = rt_head; end
      REPL:    begin we = !at_top || rt_ok; wd = lt_nx ? t : nx; end
      default: we = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    ovf   <= 1'b0;
    empty <= cnt == '0;
    full  <= cnt == CW'(D);
    if (rst) begin
      st    <= INIT;
      i     <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else case (st)
      INIT: begin
        i  <= at_top ? '0 : i + IW'(1);
        st <= at_top ? IDLE : INIT;
      end
      IDLE: begin
        i <= '0;
        t <= qq_entry_t'{key: key_i, val: val_i};
        if (enq_i && !is_sentinel(key_i)) st <= (deq_i && cnt != '0) ? REPL : ENQ;
        else if (deq_i && !enq_i && cnt != '0) st <= DEQ;
      end
      ENQ: begin
        if (lt_cur) t <= cur;
        if (is_sentinel(cur.key)) begin
          st  <= IDLE;
          cnt <= cnt + CW'(1);
        end else if (at_top) st <= ENQ_RT;
        else i <= i + IW'(1);
      end
      ENQ_RT: if (rt_ok) begin
        st  <= IDLE;
        ovf <= LAST;
      end
      DEQ: if (is_sentinel(nxt_m.key)) begin
        st  <= IDLE;
        cnt <= cnt - CW'(1);
      end else begin
        i <= i + IW'(1);
        if (i == TOP - IW'(1)) st <= DEQ_RT;
      end
      DEQ_RT: if (rt_ok) begin
        st <= IDLE;
        if (is_sentinel(rt_head.key)) cnt <= cnt - CW'(1);
      end
      REPL: if (!at_top || rt_ok) begin
        i <= i + IW'(1);
        if (lt_nx || at_top) st <= IDLE;
      end
      default: st <= INIT;
    endcase
  end
endmodule

// File: tb/tb_qq_segment.sv
// tb_qq_segment: directed checks of standalone, chained and backpressured segments
module tb_qq_segment;
  localparam logic [31:0] MAXK = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic enq [3], deq [3], rdy [3], emp [3], ful [3], ovf [3], rtenq [3], rtdeq [3];
  logic [31:0] key [3], kout [3], rtkey [3];
  logic [15:0] val [3], vout [3], rtval [3];
  logic r_rdy, r_emp, r_ful, r_ovf, r_rtenq, r_rtdeq;
  logic [31:0] r_key, r_rtkey;
  logic [15:0] r_val, r_rtval;
  logic b_rt_rdy = 1'b0;
  int total = 0, passed = 0, ovf_n = 0, ldeq_n = 0, base = 0;

  qq_segment #(.D(4), .LAST(1'b1)) u_a (
    .clk(clk), .rst(rst), .enq_i(enq[0]), .deq_i(deq[0]), .key_i(key[0]), .val_i(val[0]),
    .rdy_o(rdy[0]), .key_o(kout[0]), .val_o(vout[0]), .empty_o(emp[0]), .full_o(ful[0]),
    .ovf_o(ovf[0]), .rt_enq_o(rtenq[0]), .rt_deq_o(rtdeq[0]), .rt_key_o(rtkey[0]),
    .rt_val_o(rtval[0]), .rt_key_i(32'h0), .rt_val_i(16'h0), .rt_rdy_i(1'b0));
  qq_segment #(.D(4), .LAST(1'b0)) u_l (
    .clk(clk), .rst(rst), .enq_i(enq[1]), .deq_i(deq[1]), .key_i(key[1]), .val_i(val[1]),
    .rdy_o(rdy[1]), .key_o(kout[1]), .val_o(vout[1]), .empty_o(emp[1]), .full_o(ful[1]),
    .ovf_o(ovf[1]), .rt_enq_o(rtenq[1]), .rt_deq_o(rtdeq[1]), .rt_key_o(rtkey[1]),
    .rt_val_o(rtval[1]), .rt_key_i(r_key), .rt_val_i(r_val), .rt_rdy_i(r_rdy));
  qq_segment #(.D(4), .LAST(1'b1)) u_r (
    .clk(clk), .rst(rst), .enq_i(rtenq[1]), .deq_i(rtdeq[1]), .key_i(rtkey[1]), .val_i(rtval[1]),
    .rdy_o(r_rdy), .key_o(r_key), .val_o(r_val), .empty_o(r_emp), .full_o(r_ful),
    .ovf_o(r_ovf), .rt_enq_o(r_rtenq), .rt_deq_o(r_rtdeq), .rt_key_o(r_rtkey),
    .rt_val_o(r_rtval), .rt_key_i(32'h0), .rt_val_i(16'h0), .rt_rdy_i(1'b0));
  qq_segment #(.D(4), .LAST(1'b0)) u_b (
    .clk(clk), .rst(rst), .enq_i(enq[2]), .deq_i(deq[2]), .key_i(key[2]), .val_i(val[2]),
    .rdy_o(rdy[2]), .key_o(kout[2]), .val_o(vout[2]), .empty_o(emp[2]), .full_o(ful[2]),
    .ovf_o(ovf[2]), .rt_enq_o(rtenq[2]), .rt_deq_o(rtdeq[2]), .rt_key_o(rtkey[2]),
    .rt_val_o(rtval[2]), .rt_key_i(MAXK), .rt_val_i(16'h0), .rt_rdy_i(b_rt_rdy));

  always @(negedge clk) begin
    if (ovf[0]) ovf_n <= ovf_n + 1;
    if (rtdeq[1]) ldeq_n <= ldeq_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // n==3 selects the right-hand chain segment
  task automatic wait_rdy(input int n);
    int c = 0;
    while (!(n == 3 ? r_rdy : rdy[n]) && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (!(n == 3 ? r_rdy : rdy[n])) chk($sformatf("rdy_timeout%0d", n), 32'(n == 3 ? r_rdy : rdy[n]), 1);
  endtask

  task automatic cmd(input int n, input logic e, input logic d, input logic [31:0] k, input logic [15:0] v);
    wait_rdy(n);
    enq[n] = e;
    deq[n] = d;
    key[n] = k;
    val[n] = v;
    @(negedge clk);
    enq[n] = 1'b0;
    deq[n] = 1'b0;
  endtask

  task automatic pop(input int n, input logic [31:0] ek, input logic [15:0] ev);
    wait_rdy(n);
    chk($sformatf("pop%0d_key_%0h", n, ek), kout[n], ek);
    chk($sformatf("pop%0d_val_%0h", n, ek), 32'(vout[n]), 32'(ev));
    cmd(n, 1'b0, 1'b1, 32'h0, 16'h0);
  endtask

  task automatic repl(input int n, input logic [31:0] k, input logic [15:0] v, input logic [31:0] ek, input logic [15:0] ev);
    wait_rdy(n);
    chk($sformatf("repl%0d_key_%0h", n, k), kout[n], ek);
    chk($sformatf("repl%0d_val_%0h", n, k), 32'(vout[n]), 32'(ev));
    cmd(n, 1'b1, 1'b1, k, v);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 3; n++) begin
      enq[n] = 1'b0; deq[n] = 1'b0; key[n] = '0; val[n] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(rdy[0]), 0);
    chk("rst_key", kout[0], MAXK);
    chk("rst_empty", 32'(emp[0]), 1);
    chk("rst_full", 32'(ful[0]), 0);
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("init_rdy_c%0d", c), 32'(rdy[0]), 32'(c == 4));
      chk($sformatf("init_rt_c%0d", c), {rtenq[2], rtdeq[2], rtenq[1], rtdeq[1]}, 0);
      chk($sformatf("init_key_c%0d", c), kout[0], MAXK);
    end
    chk("init_empty", 32'(emp[0]), 1);
    // FIFO order among equal keys, payload tracking
    cmd(0, 1, 0, 5, 16'hA); cmd(0, 1, 0, 3, 16'hB); cmd(0, 1, 0, 9, 16'hC); cmd(0, 1, 0, 3, 16'hD);
    wait_rdy(0);
    chk("t2_head_key", kout[0], 3);
    chk("t2_head_val", 32'(vout[0]), 32'hB);
    @(negedge clk);
    chk("t2_full", 32'(ful[0]), 1);
    pop(0, 3, 16'hB); pop(0, 3, 16'hD); pop(0, 5, 16'hA); pop(0, 9, 16'hC);
    wait_rdy(0);
    @(negedge clk);
    chk("t2_empty", 32'(emp[0]), 1);
    chk("t2_empty_key", kout[0], MAXK);
    cmd(0, 0, 1, 0, 0);
    chk("t2_deq_empty_noop", 32'(rdy[0]), 1);
    // overflow on the last segment
    for (int k = 1; k <= 4; k++) cmd(0, 1, 0, k, 16'(k * 16));
    wait_rdy(0);
    @(negedge clk);
    chk("t3_full", 32'(ful[0]), 1);
    base = ovf_n;
    cmd(0, 1, 0, 0, 16'hEE);
    wait_rdy(0);
    @(negedge clk);
    chk("t3_ovf_once", 32'(ovf_n - base), 1);
    chk("t3_ovf_low", 32'(ovf[0]), 0);
    chk("t3_still_full", 32'(ful[0]), 1);
    pop(0, 0, 16'hEE); pop(0, 1, 16'h10); pop(0, 2, 16'h20); pop(0, 3, 16'h30);
    wait_rdy(0);
    @(negedge clk);
    chk("t3_empty", 32'(emp[0]), 1);
    // REPLACE
    cmd(0, 1, 0, 2, 16'h2); cmd(0, 1, 0, 4, 16'h4); cmd(0, 1, 0, 6, 16'h6);
    repl(0, 5, 16'h5, 2, 16'h2);
    repl(0, 1, 16'h1, 4, 16'h4);
    pop(0, 1, 16'h1); pop(0, 5, 16'h5); pop(0, 6, 16'h6);
    wait_rdy(0);
    @(negedge clk);
    chk("t5_empty", 32'(emp[0]), 1);
    for (int k = 1; k <= 4; k++) cmd(0, 1, 0, k, 16'(k));
    repl(0, 9, 16'h9, 1, 16'h1);
    cmd(0, 1, 0, MAXK, 16'h77);
    chk("t5_max_enq_ignored", 32'(rdy[0]), 1);
    cmd(0, 1, 1, MAXK, 16'h77);
    chk("t5_max_repl_ignored", 32'(rdy[0]), 1);
    pop(0, 2, 16'h2); pop(0, 3, 16'h3); pop(0, 4, 16'h4); pop(0, 9, 16'h9);
    // two-segment chain
    for (int k = 8; k >= 1; k--) cmd(1, 1, 0, k, 16'(k));
    wait_rdy(1);
    wait_rdy(3);
    @(negedge clk);
    chk("t4_left_head", kout[1], 1);
    chk("t4_left_full", 32'(ful[1]), 1);
    chk("t4_right_head", r_key, 5);
    chk("t4_right_full", 32'(r_ful), 1);
    base = ldeq_n;
    for (int k = 1; k <= 5; k++) pop(1, k, 16'(k));
    wait_rdy(1);
    wait_rdy(3);
    @(negedge clk);
    chk("t4_rt_deq_count", 32'(ldeq_n - base), 4);
    chk("t4_left_head_after", kout[1], 6);
    chk("t4_right_empty", 32'(r_emp), 1);
    chk("t4_left_not_full", 32'(ful[1]), 0);
    // REPLACE that spills across the chain boundary
    cmd(1, 1, 0, 9, 16'h9); cmd(1, 1, 0, 10, 16'hA);
    wait_rdy(3);
    base = ldeq_n;
    repl(1, 11, 16'hB, 6, 16'h6);
    wait_rdy(1);
    wait_rdy(3);
    @(negedge clk);
    chk("t4r_left_head", kout[1], 7);
    chk("t4r_right_head", r_key, 11);
    chk("t4r_rt_repl", 32'(ldeq_n - base), 1);
    // backpressure on the right handshake, then reset mid-wait
    for (int k = 1; k <= 4; k++) cmd(2, 1, 0, k, 16'(k));
    cmd(2, 1, 0, 5, 16'h5);
    begin
      int c = 0;
      while (!rtenq[2] && c < 50) begin
        @(negedge clk);
        c++;
      end
    end
    chk("t6_reach_enq_rt", 32'(rtenq[2]), 1);
    chk("t6_rt_key", rtkey[2], 5);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("t6_hold_enq_c%0d", c), 32'(rtenq[2]), 1);
      chk($sformatf("t6_hold_rdy_c%0d", c), 32'(rdy[2]), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_rt_enq", 32'(rtenq[2]), 0);
    chk("t6_rst_rdy", 32'(rdy[2]), 0);
    chk("t6_rst_key", kout[2], MAXK);
    rst = 1'b0;
    wait_rdy(2);
    chk("t6_reinit_key", kout[2], MAXK);
    chk("t6_reinit_empty", 32'(emp[2]), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
